// File: rtl/ex1_scan_ctrl.sv
// Scan controller for the ex1_1022 block: steps a wrap-capable 4-bit code range,
// captures outB/G/D after a settle delay and offers each result over valid/ready.
module ex1_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] first_code,
  input  logic [3:0] last_code,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       outB,
  input  logic       outG,
  input  logic       outD,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_code,
  output logic [2:0] res_bits,
  output logic [4:0] cnt_b,
  output logic [4:0] cnt_g,
  output logic [4:0] cnt_d,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESULT, DONE} stateT;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

  stateT      state, stateNext;
  logic [3:0] code, lastCode, settleCnt;
  logic       loadScan, capture, dropValid, advance;

  always_comb begin
    stateNext = state;
    loadScan  = 1'b0;
    capture   = 1'b0;
    dropValid = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          loadScan  = 1'b1;
          stateNext = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          dropValid = 1'b1;
          stateNext = IDLE;
        end else if (settleCnt == 4'd1) begin
          capture   = 1'b1;
          stateNext = RESULT;
        end
      end
      RESULT: begin
        // abort wins over a same-edge handshake or completion
        if (abort) begin
          dropValid = 1'b1;
          stateNext = IDLE;
        end else if (res_ready) begin
          dropValid = 1'b1;
          if (code == lastCode) begin
            stateNext = DONE;
          end else begin
            advance   = 1'b1;
            stateNext = DRIVE;
          end
        end
      end
      DONE: begin
        dropValid = abort;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      code      <= '0;
      lastCode  <= '0;
      settleCnt <= '0;
      res_valid <= 1'b0;
      res_code  <= '0;
      res_bits  <= '0;
      cnt_b     <= '0;
      cnt_g     <= '0;
      cnt_d     <= '0;
    end else begin
      state <= stateNext;

      if (loadScan) begin
        code      <= first_code;
        lastCode  <= last_code;
        settleCnt <= SETTLE_LOAD;
        cnt_b     <= '0;
        cnt_g     <= '0;
        cnt_d     <= '0;
      end else if (advance) begin
        code      <= code + 4'd1;
        settleCnt <= SETTLE_LOAD;
      end else if (state == DRIVE) begin
        settleCnt <= settleCnt - 4'd1;
      end

      if (capture) begin
        res_valid <= 1'b1;
        res_code  <= code;
        res_bits  <= {outB, outG, outD};
        cnt_b     <= cnt_b + {4'b0000, outB};
        cnt_g     <= cnt_g + {4'b0000, outG};
        cnt_d     <= cnt_d + {4'b0000, outD};
      end else if (dropValid) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    {w, x, y, z} = (state == IDLE) ? 4'b0000 : code;
  end

endmodule

// File: tb/tb_ex1_scan_ctrl.sv
// Bench for ex1_scan_ctrl: one instance with SETTLE=1 and one with SETTLE=4, each
// driving an ex1_1022 stand-in (outB=z, outG=y, outD=x).
module tb_ex1_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] first = '0;
  logic [3:0] last = '0;
  logic       sel = 1'b0;

  logic       start1, start4;
  logic       w1, x1, y1, z1, w4, x4, y4, z4;
  logic       outB1, outG1, outD1, outB4, outG4, outD4;
  logic       resValid1, resValid4, busy1, busy4, done1, done4;
  logic [3:0] resCode1, resCode4;
  logic [2:0] resBits1, resBits4;
  logic [4:0] cntB1, cntG1, cntD1, cntB4, cntG4, cntD4;

  logic [3:0] oW, oCode;
  logic [2:0] oBits;
  logic [4:0] oCntB, oCntG, oCntD;
  logic       oValid, oBusy, oDone;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start4 = start & sel;
  assign outB1 = z1;
  assign outG1 = y1;
  assign outD1 = x1;
  assign outB4 = z4;
  assign outG4 = y4;
  assign outD4 = x4;

  ex1_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .first_code(first), .last_code(last),
    .w(w1), .x(x1), .y(y1), .z(z1),
    .outB(outB1), .outG(outG1), .outD(outD1),
    .res_valid(resValid1), .res_ready(ready), .res_code(resCode1), .res_bits(resBits1),
    .cnt_b(cntB1), .cnt_g(cntG1), .cnt_d(cntD1), .busy(busy1), .done(done1)
  );

  ex1_scan_ctrl #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort),
    .first_code(first), .last_code(last),
    .w(w4), .x(x4), .y(y4), .z(z4),
    .outB(outB4), .outG(outG4), .outD(outD4),
    .res_valid(resValid4), .res_ready(ready), .res_code(resCode4), .res_bits(resBits4),
    .cnt_b(cntB4), .cnt_g(cntG4), .cnt_d(cntD4), .busy(busy4), .done(done4)
  );

  always_comb begin
    if (sel) begin
      oW = {w4, x4, y4, z4}; oValid = resValid4; oCode = resCode4; oBits = resBits4;
      oCntB = cntB4; oCntG = cntG4; oCntD = cntD4; oBusy = busy4; oDone = done4;
    end else begin
      oW = {w1, x1, y1, z1}; oValid = resValid1; oCode = resCode1; oBits = resBits1;
      oCntB = cntB1; oCntG = cntG1; oCntD = cntD1; oBusy = busy1; oDone = done1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in response for a code {w,x,y,z}: {outB,outG,outD} = {z,y,x}
  function automatic logic [2:0] expBits(input logic [3:0] c);
    return {c[0], c[1], c[2]};
  endfunction

  task automatic checkReset(input string tag);
    check({tag, "_wxyz"}, 32'(oW), 32'd0);
    check({tag, "_valid"}, 32'(oValid), 32'd0);
    check({tag, "_code"}, 32'(oCode), 32'd0);
    check({tag, "_bits"}, 32'(oBits), 32'd0);
    check({tag, "_cnts"}, 32'({oCntB, oCntG, oCntD}), 32'd0);
    check({tag, "_busy"}, 32'(oBusy), 32'd0);
    check({tag, "_done"}, 32'(oDone), 32'd0);
  endtask

  // Transaction-level model: expected code sequence by modular stepping, counts by
  // summing stub responses, completion time = N*(SETTLE+1) + stalled cycles.
  task automatic runScan(input logic [3:0] f, input logic [3:0] l,
                         input int unsigned stallPct, output int doneCyc);
    int unsigned n, s, stalls, accepted;
    int          cyc, firstValid;
    logic [3:0]  expCode[$];
    logic [3:0]  c, prevCode;
    logic [2:0]  b, prevBits;
    logic [4:0]  sumB, sumG, sumD;
    logic        holdPrev, rdy;
    s = sel ? 4 : 1;
    n = ((int'(l) - int'(f) + 16) % 16) + 1;
    sumB = '0; sumG = '0; sumD = '0;
    for (int unsigned k = 0; k < n; k++) begin
      c = 4'((int'(f) + int'(k)) % 16);
      b = expBits(c);
      expCode.push_back(c);
      sumB = sumB + 5'(b[2]);
      sumG = sumG + 5'(b[1]);
      sumD = sumD + 5'(b[0]);
    end
    first = f; last = l; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; stalls = 0; accepted = 0; firstValid = -1; doneCyc = -1;
    holdPrev = 1'b0; prevCode = '0; prevBits = '0;
    while (cyc < 600) begin
      if (holdPrev) begin
        check("holdValid", 32'(oValid), 32'd1);
        check("holdCode", 32'(oCode), 32'(prevCode));
        check("holdBits", 32'(oBits), 32'(prevBits));
      end
      if (doneCyc >= 0) begin
        check("busyAfterDone", 32'(oBusy), 32'd0);
        check("doneOnce", 32'(oDone), 32'd0);
        break;
      end
      if (oValid && firstValid < 0) firstValid = cyc;
      if (oDone) doneCyc = cyc;
      else if (oBusy && accepted < n) check("wxyz", 32'(oW), 32'(expCode[accepted]));
      holdPrev = 1'b0;
      rdy = ($urandom_range(99) >= stallPct);
      if (oValid) begin
        if (rdy) begin
          if (accepted < n) begin
            check("resCode", 32'(oCode), 32'(expCode[accepted]));
            check("resBits", 32'(oBits), 32'(expBits(expCode[accepted])));
          end else begin
            check("resultCount", 32'(accepted + 1), 32'(n));
          end
          accepted++;
        end else begin
          stalls++;
          holdPrev = 1'b1;
          prevCode = oCode;
          prevBits = oBits;
        end
      end
      ready = rdy;
      @(negedge clk);
      cyc++;
    end
    check("firstValid", 32'(firstValid), 32'(s));
    check("doneCycle", 32'(doneCyc), 32'(n * (s + 1) + stalls));
    check("accepted", 32'(accepted), 32'(n));
    check("cntB", 32'(oCntB), 32'(sumB));
    check("cntG", 32'(oCntG), 32'(sumG));
    check("cntD", 32'(oCntD), 32'(sumD));
  endtask

  typedef struct {
    logic [3:0]  first, last;
    logic [2:0]  ctl;      // {start, ready, abort}
    logic [2:0]  expSt;    // {res_valid, busy, done}
    logic        chkW;
    logic [3:0]  expW;
    logic [3:0]  expCode;
    logic [2:0]  expBits;
    logic [14:0] expCnt;   // {cnt_b, cnt_g, cnt_d}
  } vecT;

  vecT tv[15];

  initial begin
    int d;
    tv = '{
      // single code 7 with three stalled cycles
      '{4'd7, 4'd7, 3'b100, 3'b010, 1'b1, 4'd7, 4'd0, 3'b000, {5'd0, 5'd0, 5'd0}},
      '{4'd7, 4'd7, 3'b000, 3'b110, 1'b1, 4'd7, 4'd7, 3'b111, {5'd1, 5'd1, 5'd1}},
      '{4'd7, 4'd7, 3'b000, 3'b110, 1'b1, 4'd7, 4'd7, 3'b111, {5'd1, 5'd1, 5'd1}},
      '{4'd7, 4'd7, 3'b000, 3'b110, 1'b1, 4'd7, 4'd7, 3'b111, {5'd1, 5'd1, 5'd1}},
      '{4'd7, 4'd7, 3'b000, 3'b110, 1'b1, 4'd7, 4'd7, 3'b111, {5'd1, 5'd1, 5'd1}},
      '{4'd7, 4'd7, 3'b010, 3'b011, 1'b0, 4'd0, 4'd0, 3'b000, {5'd1, 5'd1, 5'd1}},
      '{4'd7, 4'd7, 3'b010, 3'b000, 1'b1, 4'd0, 4'd0, 3'b000, {5'd1, 5'd1, 5'd1}},
      // stray start and range change mid-scan, then abort in RESULT with ready
      '{4'd0, 4'd15, 3'b110, 3'b010, 1'b1, 4'd0, 4'd0, 3'b000, {5'd0, 5'd0, 5'd0}},
      '{4'd0, 4'd15, 3'b010, 3'b110, 1'b1, 4'd0, 4'd0, 3'b000, {5'd0, 5'd0, 5'd0}},
      '{4'd0, 4'd15, 3'b010, 3'b010, 1'b1, 4'd1, 4'd0, 3'b000, {5'd0, 5'd0, 5'd0}},
      '{4'd9, 4'd9, 3'b110, 3'b110, 1'b1, 4'd1, 4'd1, 3'b100, {5'd1, 5'd0, 5'd0}},
      '{4'd9, 4'd9, 3'b010, 3'b010, 1'b1, 4'd2, 4'd0, 3'b000, {5'd1, 5'd0, 5'd0}},
      '{4'd9, 4'd9, 3'b010, 3'b110, 1'b1, 4'd2, 4'd2, 3'b010, {5'd1, 5'd1, 5'd0}},
      '{4'd9, 4'd9, 3'b011, 3'b000, 1'b1, 4'd0, 4'd0, 3'b000, {5'd1, 5'd1, 5'd0}},
      '{4'd9, 4'd9, 3'b000, 3'b000, 1'b1, 4'd0, 4'd0, 3'b000, {5'd1, 5'd1, 5'd0}}
    };

    // reset values on both instances
    repeat (2) @(negedge clk);
    sel = 1'b0; #1;
    checkReset("rst1");
    sel = 1'b1; #1;
    checkReset("rst4");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      first = tv[i].first;
      last  = tv[i].last;
      {start, ready, abort} = tv[i].ctl;
      @(negedge clk);
      check($sformatf("tv%0d_st", i), 32'({oValid, oBusy, oDone}), 32'(tv[i].expSt));
      if (tv[i].chkW) check($sformatf("tv%0d_wxyz", i), 32'(oW), 32'(tv[i].expW));
      if (tv[i].expSt[2]) begin
        check($sformatf("tv%0d_code", i), 32'(oCode), 32'(tv[i].expCode));
        check($sformatf("tv%0d_bits", i), 32'(oBits), 32'(tv[i].expBits));
      end
      check($sformatf("tv%0d_cnt", i), 32'({oCntB, oCntG, oCntD}), 32'(tv[i].expCnt));
    end
    {start, ready, abort} = 3'b000;
    @(negedge clk);

    sel = 1'b0;
    runScan(4'd0, 4'd15, 0, d);
    check("fullScanDone", 32'(d), 32'd32);
    runScan(4'd14, 4'd1, 0, d);
    check("wrapScanDone", 32'(d), 32'd8);
    sel = 1'b1;
    runScan(4'd0, 4'd1, 0, d);
    check("settleScanDone", 32'(d), 32'd10);
    sel = 1'b0;
    @(negedge clk);

    // asynchronous reset while code 5 is being driven
    first = 4'd0; last = 4'd15; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("preRstWxyz", 32'(oW), 32'd5);
    check("preRstCnt", 32'({oCntB, oCntG, oCntD}), 32'({5'd2, 5'd2, 5'd1}));
    #2 rst = 1'b1;
    #1 checkReset("midRst");
    #1 rst = 1'b0;
    @(negedge clk);
    runScan(4'd0, 4'd15, 0, d);
    check("postRstScanDone", 32'(d), 32'd32);

    repeat (20) begin
      sel = 1'($urandom_range(1));
      #1;
      runScan(4'($urandom_range(15)), 4'($urandom_range(15)), $urandom_range(60), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
